bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares the single PL BRAM port between the SIMD core's instruction-fetch (IF) engine and its load/store (LS) unit. Each requester posts a burst (start address, beat count, direction). The arbiter grants one burst at a time, generates the BRAM addresses, steers read data back to the owner, and paces LS writes with a valid/ready handshake. It sits between the core's fetch/LSU and the BRAM controller inside the PL top.

## Interface
- ADDR_W, 12, BRAM word-address width
- DATA_W, 32, BRAM word width (multiple of 8)
- MAX_BURST, 16, maximum beats per burst (power of 2); LW = $clog2(MAX_BURST)
- CLK  in  1  clock, rising edge
- RSTN  in  1  synchronous, active-low reset
- IF_REQ  in  1  fetch burst request (read only)
- IF_ADDR  in  ADDR_W  start word address
- IF_LEN  in  LW  beats minus 1
- IF_GNT  out  1  one-cycle pulse: burst accepted
- IF_RVALID / IF_RDATA  out  1 / DATA_W  read beat to IF
- IF_DONE  out  1  one-cycle pulse with the last IF beat
- LS_REQ, LS_ADDR, LS_LEN  in  1, ADDR_W, LW  as IF
- LS_WE  in  1  1 = write burst, 0 = read burst
- LS_WVALID / LS_WDATA  in  1 / DATA_W  write beat offered
- LS_WREADY  out  1  write beat consumed this cycle
- LS_GNT, LS_RVALID, LS_RDATA, LS_DONE  out  as IF
- BRAM_EN  out  1  port enable
- BRAM_WE  out  DATA_W/8  byte write enables (all-ones on write, else 0)
- BRAM_ADDR / BRAM_DIN  out  ADDR_W / DATA_W
- BRAM_DOUT  in  DATA_W  read data, 1-cycle latency after BRAM_EN
- BUSY  out  1  burst active or read beat in flight

## Operation
- States: IDLE and BURST.
- **IDLE:**
  - Samples IF_REQ/LS_REQ.
  - With one request, that requester wins.
  - With both, the winner is the one not granted last (round-robin). The last-owner register resets to LS, so IF wins the first tie.
  - The winner's ADDR, LEN and WE (WE forced 0 for IF) are latched and the state moves to BURST.
- **BURST:**
  - GNT pulses for the owner in the first BURST cycle.
  - One beat is issued per cycle: BRAM_EN=1, BRAM_ADDR = current address.
  - The address increments by 1 per issued beat and wraps modulo 2^ADDR_W.
- **Read beat:** always issued. The owner tag is pipelined one stage, and the cycle after issue gives owner RVALID=1 with RDATA=BRAM_DOUT.
- **Write beat (LS only):**
  - LS_WREADY = (BURST & owner LS & WE & LS_WVALID).
  - The beat issues only when WREADY=1: BRAM_WE all-ones, BRAM_DIN=LS_WDATA.
  - With LS_WVALID=0 the cycle stalls: BRAM_EN=0 and the address and beat count hold.
- **Burst completion:**
  - After LEN+1 beats issue, the state returns to IDLE on the next edge.
  - DONE pulses: read bursts with the last RVALID; write bursts the cycle after the last write beat issues.
- **Request protocol:** the requester holds REQ until GNT and drops it the cycle after GNT. REQ high in IDLE is always a new request. ADDR/LEN/WE must be stable while REQ is high.
- **Outputs when not owner:** RDATA for the non-owner is 0 and RVALID is 0.
- **BUSY** = (state == BURST) | read beat in flight.
- **Reset** (RSTN=0 at an edge), including mid-burst:
  - State goes to IDLE.
  - Every output goes to 0, and any in-flight read is discarded (no RVALID/DONE follows).
  - Last owner resets to LS.

## Timing
- **Read burst, REQ first seen in IDLE at cycle T, length L = LEN+1:**
  - GNT and first BRAM_EN at T+1; beats T+1..T+L.
  - RVALID T+2..T+L+1; DONE at T+L+1.
  - Back in IDLE at T+L+1; the next burst issues no earlier than T+L+2.
- **Write burst without stalls:** beats T+1..T+L, DONE at T+L+1. Each LS_WVALID=0 cycle adds one cycle.
- **Single-beat burst (LEN=0):** GNT and the beat share one cycle.
- **Arbitration gap:** exactly one IDLE cycle between consecutive bursts. No preemption: a granted burst always completes unless reset.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - **Defined:** IF always wins ties, and the last-owner register is not used.
  - **Undefined (default):** round-robin as described. All other behaviour is identical.

## Test plan
- Reset, then IF_REQ with IF_ADDR=0x010, IF_LEN=3 -> IF_GNT at T+1; BRAM_ADDR 0x010..0x013 on T+1..T+4; IF_RVALID T+2..T+5 carrying preloaded words; IF_DONE at T+5.
- LS write, LS_ADDR=0x020, LS_LEN=2, LS_WVALID low for one cycle after the first beat -> writes to 0x020, 0x021, 0x022 with one BRAM_EN=0 stall cycle; LS_DONE the cycle after the 0x022 write; readback by a later LS read matches.
- IF and LS request in the same IDLE cycle, both re-requesting after each burst -> grants alternate IF, LS, IF, LS (round-robin). With `ARB_FIXED_PRIO_EN` -> IF, IF, IF.
- IF burst at IF_ADDR=0xFFE, IF_LEN=3 -> BRAM_ADDR sequence 0xFFE, 0xFFF, 0x000, 0x001.
- RSTN low at the third beat of a 16-beat read -> next cycle all outputs 0, no further RVALID/DONE, BUSY=0; a fresh request afterwards is granted normally with IF winning a tie.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester and BRAM signal bundle for the BRAM port arbiter
// slave: arbiter side; master: requesters plus BRAM controller side.
interface bram_port_arbiter_if #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
);
   localparam int LW = $clog2(MAX_BURST);
   localparam int NB = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [LW-1:0]     if_len;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;

   logic              ls_req;
   logic [ADDR_W-1:0] ls_addr;
   logic [LW-1:0]     ls_len;
   logic              ls_we;
   logic              ls_wvalid;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_wready;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   logic              ls_done;

   logic              bram_en;
   logic [NB-1:0]     bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic [DATA_W-1:0] bram_dout;
   logic              busy;

   modport slave (
      input  if_req, if_addr, if_len,
      output if_gnt, if_rvalid, if_rdata, if_done,
      input  ls_req, ls_addr, ls_len, ls_we, ls_wvalid, ls_wdata,
      output ls_wready, ls_gnt, ls_rvalid, ls_rdata, ls_done,
      output bram_en, bram_we, bram_addr, bram_din,
      input  bram_dout,
      output busy
   );

   modport master (
      output if_req, if_addr, if_len,
      input  if_gnt, if_rvalid, if_rdata, if_done,
      output ls_req, ls_addr, ls_len, ls_we, ls_wvalid, ls_wdata,
      input  ls_wready, ls_gnt, ls_rvalid, ls_rdata, ls_done,
      input  bram_en, bram_we, bram_addr, bram_din,
      output bram_dout,
      input  busy
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - burst arbiter sharing one BRAM port between instruction fetch and load/store
// Optional ARB_FIXED_PRIO_EN: fetch always wins ties instead of round-robin.
module bram_port_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input logic                clk,
   input logic                rstn,
   bram_port_arbiter_if.slave bus
);
   localparam int LW = $clog2(MAX_BURST);
   localparam int NB = DATA_W / 8;

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t            state_q, state_d;
   logic              owner_ls_q, owner_ls_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              first_q, first_d;
   logic              rd_vld_q, rd_vld_d;
   logic              rd_ls_q, rd_ls_d;
   logic              rd_last_q, rd_last_d;
   logic              wdone_q, wdone_d;
`ifndef ARB_FIXED_PRIO_EN
   logic              last_ls_q, last_ls_d;
`endif

   logic wready;
   logic issue;
   logic last_beat;
   logic pick_ls;

   always_comb begin
      state_d    = state_q;
      owner_ls_d = owner_ls_q;
      we_d       = we_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      first_d    = 1'b0;
      rd_vld_d   = 1'b0;
      rd_ls_d    = rd_ls_q;
      rd_last_d  = 1'b0;
      wdone_d    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_ls_d  = last_ls_q;
      // On a tie the requester that did not own the previous burst wins.
      pick_ls    = bus.ls_req & (~bus.if_req | ~last_ls_q);
`else
      pick_ls    = bus.ls_req & ~bus.if_req;
`endif

      wready    = (state_q == ST_BURST) & owner_ls_q & we_q & bus.ls_wvalid;
      issue     = (state_q == ST_BURST) & (~we_q | wready);
      last_beat = issue & (cnt_q == '0);

      case (state_q)
         ST_IDLE: begin
            if (bus.if_req | bus.ls_req) begin
               state_d    = ST_BURST;
               first_d    = 1'b1;
               owner_ls_d = pick_ls;
               addr_d     = pick_ls ? bus.ls_addr : bus.if_addr;
               cnt_d      = pick_ls ? bus.ls_len : bus.if_len;
               we_d       = pick_ls & bus.ls_we;
`ifndef ARB_FIXED_PRIO_EN
               last_ls_d  = pick_ls;
`endif
            end
         end
         ST_BURST: begin
            if (issue) begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (!we_q) begin
                  rd_vld_d  = 1'b1;
                  rd_ls_d   = owner_ls_q;
                  rd_last_d = last_beat;
               end
               if (last_beat) begin
                  state_d = ST_IDLE;
                  wdone_d = we_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         owner_ls_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_ls_q    <= 1'b0;
         rd_last_q  <= 1'b0;
         wdone_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_ls_q  <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         owner_ls_q <= owner_ls_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         rd_vld_q   <= rd_vld_d;
         rd_ls_q    <= rd_ls_d;
         rd_last_q  <= rd_last_d;
         wdone_q    <= wdone_d;
`ifndef ARB_FIXED_PRIO_EN
         last_ls_q  <= last_ls_d;
`endif
      end
   end

   assign bus.if_gnt    = first_q & ~owner_ls_q;
   assign bus.ls_gnt    = first_q & owner_ls_q;
   assign bus.if_rvalid = rd_vld_q & ~rd_ls_q;
   assign bus.ls_rvalid = rd_vld_q & rd_ls_q;
   assign bus.if_rdata  = (rd_vld_q & ~rd_ls_q) ? bus.bram_dout : '0;
   assign bus.ls_rdata  = (rd_vld_q & rd_ls_q) ? bus.bram_dout : '0;
   assign bus.if_done   = rd_vld_q & rd_last_q & ~rd_ls_q;
   assign bus.ls_done   = (rd_vld_q & rd_last_q & rd_ls_q) | wdone_q;
   assign bus.ls_wready = wready;
   assign bus.bram_en   = issue;
   assign bus.bram_we   = (issue & we_q) ? {NB{1'b1}} : '0;
   assign bus.bram_addr = issue ? addr_q : '0;
   assign bus.bram_din  = (issue & we_q) ? bus.ls_wdata : '0;
   assign bus.busy      = (state_q == ST_BURST) | rd_vld_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter with a burst-level reference model
module tb_bram_port_arbiter;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bram_port_arbiter_if #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(16)) bus ();
   bram_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(16)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic ls;
      logic b2b;
      int   req_cyc;
      int   len;
      logic we;
   } gnt_exp_t;

   typedef struct {
      logic [11:0] addr;
      logic        we;
      logic [31:0] din;
   } beat_exp_t;

   gnt_exp_t    gnt_q[$];
   beat_exp_t   beat_q[$];
   logic [31:0] if_rd_q[$];
   logic [31:0] ls_rd_q[$];
   logic        done_q[$];
   logic [31:0] wfeed_q[$];

   logic [31:0] mem[4096];
   logic [31:0] ref_mem[4096];
   logic        last_ls = 1'b1;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   int          stall_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.bram_en) begin
         if (bus.bram_we != 4'h0) mem[bus.bram_addr] <= bus.bram_din;
         bus.bram_dout <= mem[bus.bram_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endtask

   task automatic flush_all();
      gnt_q.delete();
      beat_q.delete();
      if_rd_q.delete();
      ls_rd_q.delete();
      done_q.delete();
      wfeed_q.delete();
   endtask

   // Reference model: one burst expands into its grant, beat addresses and read data.
   task automatic push_burst(input logic ls, input logic we, input logic [11:0] addr,
                             input int len, input logic b2b, input int req_cyc);
      gnt_exp_t  g;
      beat_exp_t b;
      logic [11:0] a;
      logic [31:0] d;
      g.ls = ls; g.b2b = b2b; g.req_cyc = req_cyc; g.len = len; g.we = we;
      gnt_q.push_back(g);
      for (int i = 0; i <= len; i++) begin
         a = addr + 12'(i);
         if (we) begin
            d = $urandom;
            ref_mem[a] = d;
            wfeed_q.push_back(d);
            b.addr = a; b.we = 1'b1; b.din = d;
         end else begin
            b.addr = a; b.we = 1'b0; b.din = 32'h0;
            if (ls) ls_rd_q.push_back(ref_mem[a]);
            else    if_rd_q.push_back(ref_mem[a]);
         end
         beat_q.push_back(b);
      end
      done_q.push_back(ls);
      last_ls = ls;
   endtask

   task automatic wait_idle();
      int t = 0;
      forever begin
         @(negedge clk);
         if (!bus.busy && !bus.if_req && !bus.ls_req && gnt_q.size() == 0 && beat_q.size() == 0 &&
             if_rd_q.size() == 0 && ls_rd_q.size() == 0 && done_q.size() == 0 && wfeed_q.size() == 0)
            break;
         t++;
         if (t > 1000) begin
            flag("idle_timeout");
            flush_all();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input bit do_if, input logic [11:0] ia, input int il,
                          input bit do_ls, input logic [11:0] la, input int ll, input bit lwe);
      int  rc;
      bit  win_ls, pend_if, pend_ls, gi, gl;
      int  t;
      wait_idle();
      if (do_if) begin bus.if_req = 1'b1; bus.if_addr = ia; bus.if_len = 4'(il); end
      if (do_ls) begin bus.ls_req = 1'b1; bus.ls_addr = la; bus.ls_len = 4'(ll); bus.ls_we = lwe; end
      rc = cyc;
      if (do_if && do_ls) begin
`ifdef ARB_FIXED_PRIO_EN
         win_ls = 1'b0;
`else
         win_ls = ~last_ls;
`endif
         if (win_ls) begin
            push_burst(1'b1, lwe, la, ll, 1'b0, rc);
            push_burst(1'b0, 1'b0, ia, il, 1'b1, rc);
         end else begin
            push_burst(1'b0, 1'b0, ia, il, 1'b0, rc);
            push_burst(1'b1, lwe, la, ll, 1'b1, rc);
         end
      end else if (do_if) begin
         push_burst(1'b0, 1'b0, ia, il, 1'b0, rc);
      end else begin
         push_burst(1'b1, lwe, la, ll, 1'b0, rc);
      end
      pend_if = do_if;
      pend_ls = do_ls;
      t = 0;
      while ((pend_if || pend_ls) && t < 300) begin
         @(negedge clk);
         gi = bus.if_gnt;
         gl = bus.ls_gnt;
         @(posedge clk);
         #1;
         if (gi) begin bus.if_req = 1'b0; pend_if = 1'b0; end
         if (gl) begin bus.ls_req = 1'b0; pend_ls = 1'b0; end
         t++;
      end
      if (pend_if || pend_ls) begin
         flag("gnt_timeout");
         bus.if_req = 1'b0;
         bus.ls_req = 1'b0;
      end
   endtask

   // Write-beat feeder: offers queued LS write data, with random or scripted gaps.
   initial begin
      bit hold = 1'b0;
      int taken = 0;
      bus.ls_wvalid = 1'b0;
      bus.ls_wdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (wfeed_q.size() == 0) taken = 0;
         if (hold) begin
            bus.ls_wvalid = 1'b0;
            hold = 1'b0;
         end else if (stall_mode == 1) begin
            bus.ls_wvalid = (wfeed_q.size() > 0);
         end else begin
            bus.ls_wvalid = (wfeed_q.size() > 0) && ($urandom_range(0, 3) != 0);
         end
         bus.ls_wdata = bus.ls_wvalid ? wfeed_q[0] : $urandom;
         @(negedge clk);
         if (bus.ls_wready && wfeed_q.size() > 0) begin
            void'(wfeed_q.pop_front());
            if (stall_mode == 1 && taken == 0) hold = 1'b1;
            taken++;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event.
   int   beats_left = 0;
   logic cur_we = 1'b0;
   logic cur_ls = 1'b0;
   int   last_issue_cyc = 0;
   logic prev_rd = 1'b0;
   logic prev_rd_ls = 1'b0;

   initial begin
      gnt_exp_t  g;
      beat_exp_t b;
      logic      dl;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            beats_left = 0;
            prev_rd    = 1'b0;
         end else begin
            if (bus.if_gnt || bus.ls_gnt) begin
               chk("gnt_onehot", 64'(bus.if_gnt & bus.ls_gnt), 64'h0);
               if (gnt_q.size() == 0) flag("gnt_unexpected");
               else begin
                  g = gnt_q.pop_front();
                  chk("gnt_owner", 64'(bus.ls_gnt), 64'(g.ls));
                  if (g.b2b) chk("gnt_gap", 64'(cyc - last_issue_cyc), 64'd2);
                  else       chk("gnt_latency", 64'(cyc), 64'(g.req_cyc + 1));
                  beats_left = g.len + 1;
                  cur_we = g.we;
                  cur_ls = g.ls;
               end
            end
            if (bus.bram_en) begin
               if (beats_left == 0 || beat_q.size() == 0) flag("beat_unexpected");
               else begin
                  b = beat_q.pop_front();
                  chk("beat_addr", 64'(bus.bram_addr), 64'(b.addr));
                  chk("beat_we", 64'(bus.bram_we), b.we ? 64'hF : 64'h0);
                  if (b.we) chk("beat_din", 64'(bus.bram_din), 64'(b.din));
                  beats_left--;
                  last_issue_cyc = cyc;
               end
            end else if (beats_left > 0) begin
               chk("stall_cause", 64'({cur_we, bus.ls_wvalid}), 64'b10);
            end
            chk("if_rvalid_timing", 64'(bus.if_rvalid), 64'(prev_rd & ~prev_rd_ls));
            chk("ls_rvalid_timing", 64'(bus.ls_rvalid), 64'(prev_rd & prev_rd_ls));
            if (bus.if_rvalid) begin
               if (if_rd_q.size() == 0) flag("if_rdata_unexpected");
               else chk("if_rdata", 64'(bus.if_rdata), 64'(if_rd_q.pop_front()));
            end else chk("if_rdata_idle", 64'(bus.if_rdata), 64'h0);
            if (bus.ls_rvalid) begin
               if (ls_rd_q.size() == 0) flag("ls_rdata_unexpected");
               else chk("ls_rdata", 64'(bus.ls_rdata), 64'(ls_rd_q.pop_front()));
            end else chk("ls_rdata_idle", 64'(bus.ls_rdata), 64'h0);
            if (bus.if_done || bus.ls_done) begin
               chk("done_onehot", 64'(bus.if_done & bus.ls_done), 64'h0);
               if (done_q.size() == 0) flag("done_unexpected");
               else begin
                  dl = done_q.pop_front();
                  chk("done_owner", 64'(bus.ls_done), 64'(dl));
                  chk("done_cycle", 64'(cyc), 64'(last_issue_cyc + 1));
               end
            end
            prev_rd    = bus.bram_en && (bus.bram_we == 4'h0);
            prev_rd_ls = cur_ls;
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_en"}, 64'(bus.bram_en), 64'h0);
      chk({tag, "_we"}, 64'(bus.bram_we), 64'h0);
      chk({tag, "_addr"}, 64'(bus.bram_addr), 64'h0);
      chk({tag, "_din"}, 64'(bus.bram_din), 64'h0);
      chk({tag, "_gnt"}, 64'({bus.if_gnt, bus.ls_gnt}), 64'h0);
      chk({tag, "_rvalid"}, 64'({bus.if_rvalid, bus.ls_rvalid}), 64'h0);
      chk({tag, "_rdata"}, 64'(bus.if_rdata | bus.ls_rdata), 64'h0);
      chk({tag, "_done"}, 64'({bus.if_done, bus.ls_done}), 64'h0);
      chk({tag, "_wready"}, 64'(bus.ls_wready), 64'h0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
   endtask

   initial begin
      int t;
      int k;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_len = '0;
      bus.ls_req = 1'b0; bus.ls_addr = '0; bus.ls_len = '0; bus.ls_we = 1'b0;
      bus.bram_dout = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      mon_en = 1'b1;

      run_req(1'b1, 12'h010, 3, 1'b0, 12'h0, 0, 1'b0);
      stall_mode = 1;
      run_req(1'b0, 12'h0, 0, 1'b1, 12'h020, 2, 1'b1);
      stall_mode = 0;
      run_req(1'b0, 12'h0, 0, 1'b1, 12'h020, 2, 1'b0);
      for (int i = 0; i < 4; i++) run_req(1'b1, 12'h100 + 12'(i * 8), 1, 1'b1, 12'h200 + 12'(i * 8), 1, 1'b0);
      run_req(1'b1, 12'hFFE, 3, 1'b0, 12'h0, 0, 1'b0);
      run_req(1'b1, 12'h040, 0, 1'b1, 12'h050, 0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 3);
         run_req(k != 1, 12'($urandom), $urandom_range(0, 15),
                 k != 0, 12'($urandom), $urandom_range(0, 15), 1'($urandom));
      end

      // Reset in the middle of a 16-beat read.
      wait_idle();
      bus.if_req = 1'b1; bus.if_addr = 12'h300; bus.if_len = 4'hF;
      push_burst(1'b0, 1'b0, 12'h300, 15, 1'b0, cyc);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.if_gnt && t < 50);
      if (t >= 50) flag("rst_gnt_timeout");
      @(posedge clk);
      #1;
      bus.if_req = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rstn = 1'b1;
      flush_all();
      last_ls = 1'b1;
      @(negedge clk);
      check_outputs_zero("midrst");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'({bus.if_rvalid, bus.ls_rvalid, bus.if_done, bus.ls_done, bus.bram_en}), 64'h0);
      end
      mon_en = 1'b1;
      run_req(1'b1, 12'h400, 2, 1'b1, 12'h410, 2, 1'b0);

      wait_idle();
      chk("queues_drained", 64'(gnt_q.size() + beat_q.size() + if_rd_q.size() + ls_rd_q.size() + done_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
